// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: EX-stage execute unit. Single-cycle integer ALU ops plus
// iterative multiply (shift-add) and divide (restoring), one bit per cycle,
// behind a valid/ready handshake with a registered result and sideband tag.
module alu_mdu_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_nz
);

  localparam int SW = $clog2(XLEN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLT    = 5'd5;
  localparam logic [4:0] OP_SLTU   = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_SRL    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Single-cycle integer result; illegal op codes produce zero.
  function automatic logic [XLEN-1:0] alu_result(input logic [4:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic        [SW-1:0]   shamt;
    logic        [XLEN-1:0] r;
    sa    = $signed(a);
    sb    = $signed(b);
    shamt = b[SW-1:0];
    r     = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r[0] = (sa < sb);
      OP_SLTU: r[0] = (a < b);
      OP_SLL:  r = a << shamt;
      OP_SRL:  r = a >> shamt;
      OP_SRA:  r = $unsigned(sa >>> shamt);
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [2:0]        state_q,   state_d;
  logic [SW-1:0]     cnt_q,     cnt_d;
  logic [4:0]        op_q,      op_d;
  logic [TAG_W-1:0]  tag_q,     tag_d;
  logic [XLEN-1:0]   a_q,       a_d;
  logic [XLEN-1:0]   b_q,       b_d;
  logic [XLEN-1:0]   ma_q,      ma_d;
  logic [XLEN-1:0]   mb_q,      mb_d;
  logic [2*XLEN-1:0] acc_q,     acc_d;
  logic              neg_q,     neg_d;
  logic              negr_q,    negr_d;
  logic              out_valid_q,  out_valid_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic [TAG_W-1:0]  out_tag_q,    out_tag_d;

  logic              accept;
  logic              in_is_mul;
  logic              in_is_div;
  logic              a_sgn;
  logic              b_sgn;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_r;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic              b_zero;
  logic              sdiv_ovf;
  logic [XLEN-1:0]   fix_result;

  assign in_ready   = (state_q == S_IDLE) && !flush;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_nz     = |out_result_q;

  // Operand conditioning at accept: magnitudes plus result signs per op.
  assign in_is_mul = (in_op >= OP_MUL) && (in_op <= OP_MULHU);
  assign in_is_div = (in_op >= OP_DIV) && (in_op <= OP_REMU);
  assign a_sgn     = (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                     (in_op == OP_DIV)  || (in_op == OP_REM);
  assign b_sgn     = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
  assign a_neg     = a_sgn && in_a[XLEN-1];
  assign b_neg     = b_sgn && in_b[XLEN-1];
  assign abs_a     = a_neg ? (~in_a + 1'b1) : in_a;
  assign abs_b     = b_neg ? (~in_b + 1'b1) : in_b;

  // One shift-add step: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, ma_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring-divide step: acc = {partial remainder, dividend/quotient}.
  assign div_r    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_r - {1'b0, mb_q};
  assign div_ge   = (div_r >= {1'b0, mb_q});
  assign div_next = div_ge ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                           : {div_r[XLEN-1:0],    acc_q[XLEN-2:0], 1'b0};

  // Final sign correction, half/quotient selection and divide corner cases.
  always_comb begin
    prod_s     = neg_q  ? (~acc_q + 1'b1) : acc_q;
    quo_s      = neg_q  ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_s      = negr_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    b_zero     = (b_q == '0);
    sdiv_ovf   = (a_q == MOST_NEG) && (b_q == '1);
    fix_result = '0;
    case (op_q)
      OP_MUL:                        fix_result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_s[2*XLEN-1:XLEN];
      OP_DIV:  fix_result = b_zero ? '1  : (sdiv_ovf ? a_q : quo_s);
      OP_DIVU: fix_result = b_zero ? '1  : quo_s;
      OP_REM:  fix_result = b_zero ? a_q : (sdiv_ovf ? '0 : rem_s);
      OP_REMU: fix_result = b_zero ? a_q : rem_s;
      default: fix_result = '0;
    endcase
  end

  // Next-state logic for the FSM, iteration datapath and output registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    tag_d        = tag_q;
    a_d          = a_q;
    b_d          = b_q;
    ma_d         = ma_q;
    mb_d         = mb_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    negr_d       = negr_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = in_op;
          tag_d = in_tag;
          a_d   = in_a;
          b_d   = in_b;
          if (in_is_mul || in_is_div) begin
            ma_d    = abs_a;
            mb_d    = abs_b;
            neg_d   = a_neg ^ b_neg;
            negr_d  = a_neg;
            cnt_d   = '0;
            acc_d   = in_is_mul ? {{XLEN{1'b0}}, abs_b} : {{XLEN{1'b0}}, abs_a};
            state_d = in_is_mul ? S_MUL : S_DIV;
          end else begin
            out_result_d = alu_result(in_op, in_a, in_b);
            out_tag_d    = in_tag;
            out_valid_d  = 1'b1;
            state_d      = S_DONE;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_MUL) ? mul_next : div_next;
        cnt_d = cnt_q + SW'(1);
        if (cnt_q == SW'(XLEN-1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        out_result_d = fix_result;
        out_tag_d    = tag_q;
        out_valid_d  = 1'b1;
        state_d      = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Redirect kill wins over everything; the last delivered result is kept.
    if (flush) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      out_valid_d  = 1'b0;
      out_result_d = out_result_q;
      out_tag_d    = out_tag_q;
    end
  end

  // State, operand and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      tag_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      ma_q         <= '0;
      mb_q         <= '0;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      negr_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ma_q         <= ma_d;
      mb_q         <= mb_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      negr_q       <= negr_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Testbench for alu_mdu_seq: directed operations with literal expectations,
// plus an arithmetic reference model checked every cycle by a monitor.
module tb_alu_mdu_seq;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_nz;

  alu_mdu_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_nz(out_nz)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Outstanding-operation bookkeeping shared between driver and monitor.
  logic             pend = 1'b0;
  logic             seen = 1'b0;
  logic [4:0]       p_op;
  logic [XLEN-1:0]  p_a;
  logic [XLEN-1:0]  p_b;
  logic [TAG_W-1:0] p_tag;
  int               acc_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference results straight from the RV32I/M definitions.
  function automatic logic [31:0] model(input logic [4:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sbu, ps;
    logic        [63:0] pu;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sbu = {32'b0, b};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return {31'b0, $signed(a) < $signed(b)};
      5'd6:  return {31'b0, a < b};
      5'd7:  return a << b[4:0];
      5'd8:  return a >> b[4:0];
      5'd9:  return $signed(a) >>> b[4:0];
      5'd10: begin ps = sa * sb;  return ps[31:0];  end
      5'd11: begin ps = sa * sb;  return ps[63:32]; end
      5'd12: begin ps = sa * sbu; return ps[63:32]; end
      5'd13: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      5'd14: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return $signed(a) / $signed(b);
      end
      5'd15: return (b == 0) ? 32'hFFFFFFFF : a / b;
      5'd16: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      5'd17: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Per-cycle monitor: handshake readiness, out_nz, result/tag and latency.
  always @(negedge clk) begin
    if (rstn) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, !pend && !flush});
      chk("out_nz", {31'b0, out_nz}, {31'b0, out_result != 0});
      if (out_valid) begin
        if (!pend) begin
          chk("spurious_valid", {31'b0, out_valid}, 32'h0);
        end else begin
          chk("model_result", out_result, model(p_op, p_a, p_b));
          chk("model_tag", {28'b0, out_tag}, {28'b0, p_tag});
          if (!seen) begin
            chk("latency", 32'(cyc - acc_cyc),
                (p_op >= 5'd10 && p_op <= 5'd17) ? 32'd33 : 32'd0);
            seen = 1'b1;
          end
        end
      end
    end
  end

  // Present one op and return right after the accepting edge.
  task automatic accept_op(input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tag);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    p_op = op; p_a = a; p_b = b; p_tag = tag;
    acc_cyc = cyc;
    seen = 1'b0;
    pend = 1'b1;
  endtask

  // Full transaction: accept, wait bounded for the result, optionally stall,
  // then complete the output handshake.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] exp, input int hold);
    logic got;
    logic [31:0] r0;
    logic [3:0]  t0;
    accept_op(op, a, b, tag);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL timeout: no out_valid for tag %0d op %0d", tag, op);
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0; pend = 1'b0;
    end else begin
      chk("result", out_result, exp);
      chk("tag", {28'b0, out_tag}, {28'b0, tag});
      chk("nz", {31'b0, out_nz}, {31'b0, exp != 0});
      r0 = out_result;
      t0 = out_tag;
      repeat (hold) @(negedge clk);
      if (hold > 0) begin
        chk("hold_valid", {31'b0, out_valid}, 32'h1);
        chk("hold_result", out_result, r0);
        chk("hold_tag", {28'b0, out_tag}, {28'b0, t0});
        chk("hold_ready", {31'b0, in_ready}, 32'h0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0; pend = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_tag", {28'b0, out_tag}, 32'h0);
    chk("rst_ready", {31'b0, in_ready}, 32'h1);

    // Pin the reference model with hand-derived values.
    chk("pin_mulhsu", model(5'd12, 32'h2, 32'hFFFFFFFF), 32'h1);
    chk("pin_mulh", model(5'd11, 32'h80000000, 32'h80000000), 32'h40000000);
    chk("pin_rem", model(5'd16, 32'hFFFFFFF9, 32'h2), 32'hFFFFFFFF);
    chk("pin_sra", model(5'd9, 32'h80000000, 32'h21), 32'hC0000000);

    // Single-cycle ops.
    run_op(5'd0,  32'h7FFFFFFF, 32'h1,        4'd1, 32'h80000000, 0);
    run_op(5'd1,  32'h5,        32'h5,        4'd2, 32'h0,        0);
    run_op(5'd9,  32'h80000000, 32'h21,       4'd3, 32'hC0000000, 0);
    run_op(5'd5,  32'hFFFFFFFF, 32'h1,        4'd4, 32'h1,        0);
    run_op(5'd6,  32'hFFFFFFFF, 32'h1,        4'd5, 32'h0,        0);
    run_op(5'd7,  32'h1,        32'h1F,       4'd6, 32'h80000000, 0);
    run_op(5'd8,  32'h80000000, 32'h4,        4'd7, 32'h08000000, 0);
    run_op(5'd2,  32'hF0F0F0F0, 32'hFF00FF00, 4'd8, 32'hF000F000, 0);
    run_op(5'd3,  32'hF0F0F0F0, 32'h0F000000, 4'd9, 32'hFFF0F0F0, 0);
    run_op(5'd4,  32'hFFFF0000, 32'hFF00FF00, 4'd10, 32'h00FFFF00, 0);
    run_op(5'd20, 32'h12345678, 32'h1,        4'd11, 32'h0,        0);

    // Multiply.
    run_op(5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 32'h0,        0);
    run_op(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'hFFFFFFFE, 0);
    run_op(5'd10, 32'h7,        32'hFFFFFFFD, 4'd3, 32'hFFFFFFEB, 0);
    run_op(5'd12, 32'hFFFFFFFF, 32'h2,        4'd4, 32'hFFFFFFFF, 0);
    run_op(5'd12, 32'h2,        32'hFFFFFFFF, 4'd5, 32'h1,        0);
    run_op(5'd11, 32'h80000000, 32'h80000000, 4'd6, 32'h40000000, 0);

    // Divide, including corner cases and backpressure.
    run_op(5'd14, 32'hFFFFFFF9, 32'h2,        4'd7, 32'hFFFFFFFD, 0);
    run_op(5'd16, 32'hFFFFFFF9, 32'h2,        4'd8, 32'hFFFFFFFF, 0);
    run_op(5'd15, 32'h7,        32'h0,        4'd9, 32'hFFFFFFFF, 10);
    run_op(5'd16, 32'h80000000, 32'hFFFFFFFF, 4'd10, 32'h0,       0);
    run_op(5'd14, 32'h80000000, 32'hFFFFFFFF, 4'd11, 32'h80000000, 0);
    run_op(5'd17, 32'h7,        32'h0,        4'd12, 32'h7,       0);
    run_op(5'd15, 32'd100,      32'd7,        4'd13, 32'd14,      0);
    run_op(5'd17, 32'd100,      32'd7,        4'd14, 32'd2,       0);
    run_op(5'd14, 32'h80000000, 32'h0,        4'd15, 32'hFFFFFFFF, 0);

    // Flush in the middle of a MULHU; its tag must never come back.
    accept_op(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5);
    repeat (12) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; pend = 1'b0;
    @(negedge clk);
    chk("ready_after_flush", {31'b0, in_ready}, 32'h1);
    chk("valid_after_flush", {31'b0, out_valid}, 32'h0);
    run_op(5'd0, 32'h10, 32'h20, 4'd6, 32'h30, 0);
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a divide.
    accept_op(5'd14, 32'd100, 32'd7, 4'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rstn = 1'b0; pend = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("async_rst_result", out_result, 32'h0);
    chk("async_rst_tag", {28'b0, out_tag}, 32'h0);
    @(posedge clk);
    #1 rstn = 1'b1;
    run_op(5'd0, 32'h1, 32'h2, 4'd8, 32'h3, 0);
    run_op(5'd15, 32'd100, 32'd7, 4'd9, 32'd14, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
